// File: rtl/period_meter_if.sv
// Purpose : groups the measured input and the measurement results of period_meter.
// Latency : n/a (signal bundle only).
// Backpressure: none; all results are strobes or levels with no ready.
//
// Signals:
//   slow_in      - slow clock being measured (asynchronous to clk)
//   period       - clk cycles between the two most recent slow_in rising edges
//   period_valid - one-cycle strobe, period updated this cycle
//   timeout      - level, no slow_in rising edge within the timeout window
//   edge_seen    - one-cycle strobe per detected slow_in rising edge
interface period_meter_if #(
    parameter int unsigned CNT_W = 28
);
    logic             slow_in;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             timeout;
    logic             edge_seen;

    // Side that produces the measurement (the meter itself).
    modport slave (
        input  slow_in,
        output period,
        output period_valid,
        output timeout,
        output edge_seen
    );

    // Side that supplies slow_in and consumes the results.
    modport master (
        output slow_in,
        input  period,
        input  period_valid,
        input  timeout,
        input  edge_seen
    );
endinterface

// File: rtl/period_meter.sv
// Purpose : measures the clk-cycle period of an asynchronous slow clock, flags a stall.
// Latency : fixed 3 clk cycles from slow_in sample to edge_seen / period_valid.
// Backpressure: none; results are strobes/levels, consumer must take them as they come.
//
// Ports:
//   clk    - system clock, all logic on its rising edge
//   reset  - synchronous active-high reset, overrides every other event
//   pm     - period_meter_if.slave: slow_in in; period, period_valid, timeout, edge_seen out
module period_meter #(
    parameter int unsigned CNT_W          = 28,
    parameter int unsigned TIMEOUT_CYCLES = 150_000_000
) (
    input  logic          clk,
    input  logic          reset,
    period_meter_if.slave pm
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALLED = 2'd2
    } state_t;

    // Synchronizer and edge detect.
    logic sync1, sync2, sync3;
    logic v1, v2;
    logic armed;
    logic edge_q;
    logic edge_det;

    // FSM state and registered outputs.
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] period_q, period_nxt;
    logic             pv_q, pv_nxt;
    logic             es_q, es_nxt;
    logic             to_q, to_nxt;

    // sync2/sync3 hold reset values (0) for the first cycles after reset, which
    // would fake a rising edge if slow_in is already high. armed only rises once
    // sync2 has carried a genuine low sample (v2 marks sync2 as genuine), so a
    // level that is high across reset release is never reported as an edge.
    assign edge_det = sync2 & ~sync3 & armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync3    <= 1'b0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            armed    <= 1'b0;
            edge_q   <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            es_q     <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            sync1    <= pm.slow_in;
            sync2    <= sync1;
            sync3    <= sync2;
            v1       <= 1'b1;
            v2       <= v1;
            armed    <= armed | (v2 & ~sync2);
            // Extra stage so every edge reaches the outputs exactly 3 cycles
            // after it was sampled, independent of FSM state.
            edge_q   <= edge_det;
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            period_q <= period_nxt;
            pv_q     <= pv_nxt;
            es_q     <= es_nxt;
            to_q     <= to_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        period_nxt = period_q;
        pv_nxt     = 1'b0;
        es_nxt     = edge_q;
        to_nxt     = to_q;
        case (state)
            IDLE: begin
                if (edge_q) begin
                    cnt_nxt   = '0;
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                // An edge on the last counting cycle takes priority over the
                // timeout, so edges exactly TIMEOUT_CYCLES apart still measure.
                if (edge_q) begin
                    period_nxt = cnt + CNT_ONE;
                    pv_nxt     = 1'b1;
                    cnt_nxt    = '0;
                end else if (cnt == CNT_LAST) begin
                    to_nxt    = 1'b1;
                    state_nxt = STALLED;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            STALLED: begin
                // First edge after a stall only re-establishes the reference.
                if (edge_q) begin
                    to_nxt    = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = MEASURE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign pm.period       = period_q;
    assign pm.period_valid = pv_q;
    assign pm.edge_seen    = es_q;
    assign pm.timeout      = to_q;

endmodule
